booth_radix4_multiplier: RTL
============================

// Module: booth_radix4_multiplier
// PURPOSE
//   Sequential radix-4 Booth multiplier. Parametrised successor to the 16-bit radix-2 datapath/control pair.
//   Takes both operands in one valid/ready transfer and supports signed or unsigned mode per operation.
//   Retires 2 multiplier bits per cycle, so it runs in about half the cycles of radix-2.
//   Sits between an operand producer and a result consumer; every port is registered to clk.
// PARAMETERS
//   DATA_WIDTH   16              operand width; even, >= 4
//   OUTPUT_WIDTH 2*DATA_WIDTH    product width; must equal 2*DATA_WIDTH (elaboration error otherwise)
// PORTS
//   clk           in   1             rising-edge clock; the only clock
//   clear         in   1             synchronous active-high reset
//   in_valid      in   1             operand pair valid
//   in_ready      out  1             block can accept operands
//   multiplicand  in   DATA_WIDTH    M
//   multiplier    in   DATA_WIDTH    Q
//   signed_mode   in   1             1: two's-complement operands; 0: unsigned; sampled on accept
//   out_valid     out  1             product valid
//   out_ready     in   1             consumer takes product
//   product       out  OUTPUT_WIDTH  exact M*Q, interpreted per the sampled signed_mode
//   busy          out  1             high in RUN or DONE
// BEHAVIOUR
//   - Reset (clear=1 at an edge): state=IDLE, in_ready=1, out_valid=0, busy=0, product=0, all internal regs 0.
//     Reset has priority over every other event, including mid-RUN and DONE; the in-flight operation is discarded.
//   - FSM states: IDLE -> RUN -> DONE -> IDLE.
//     IDLE: in_ready=1. On accept (in_valid&&in_ready), load M, Q and mode; set A=0, q[-1]=0, cnt=K; go to RUN.
//     RUN: in_ready=0. Each cycle does one iteration; at the edge where cnt reaches 0, go to DONE.
//     DONE: out_valid=1 and product held stable. On out_ready=1, go to IDLE; out_valid drops the next cycle.
//   - Iteration count K: DATA_WIDTH/2 when signed; DATA_WIDTH/2+1 when unsigned.
//     In unsigned mode Q is zero-extended by 2 bits so the top digit is non-negative.
//   - Each iteration:
//     recode the window {q1,q0,q[-1]} to a digit d in {-2,-1,0,+1,+2};
//     A <= A + d*M;
//     then arithmetic-shift {A,Q,q[-1]} right by 2.
//     A is DATA_WIDTH+2 bits wide. M is sign-extended (signed) or zero-extended (unsigned) before use.
//   - Latency: out_valid rises K cycles after the accept edge. Signed W=16: 8 cycles. Unsigned W=16: 9 cycles.
//   - Throughput: one bubble cycle per operation (DONE->IDLE). in_valid is ignored while in_ready=0.
//   - product keeps its last value in IDLE until the next result or a clear.
//   - Boundary cases:
//     most-negative x most-negative is exact (no overflow in 2W bits);
//     out_ready asserted while in IDLE/RUN has no effect;
//     an out_ready held high lets DONE last exactly 1 cycle.
// CONFIGURATION
//   BOOTH_ZERO_BYPASS_EN defined:
//     on accept with M==0 or Q==0, go straight to DONE with product=0.
//     out_valid is then high 1 cycle after the accept edge.
//   BOOTH_ZERO_BYPASS_EN undefined:
//     zero operands take the full K iterations; the result is identical.
// STRUCTURE
//   - booth_pkg holds:
//     the state enum (IDLE, RUN, DONE);
//     the Booth digit encoding {neg, two, zero};
//     the functions iter_count(width, signed_mode) and a counter width of clog2(DATA_WIDTH/2+2).
//   - One sub-module, booth_r4_recoder: combinational 3-bit window -> {neg, two, zero}.
//   - FSM, counter and datapath registers stay in this module.
// TESTING (DATA_WIDTH=16 unless noted)
//   1. signed, M=0x8000, Q=0x8000 -> product=0x4000_0000; out_valid exactly 8 cycles after accept.
//   2. unsigned, M=0xFFFF, Q=0xFFFF -> product=0xFFFE_0001 after 9 cycles.
//      Same operands in signed mode -> 0x0000_0001.
//   3. signed, M=0xFFFF(-1), Q=0x0003 -> 0xFFFF_FFFD.
//      unsigned, M=0x00FF, Q=0x0100 -> 0x0000_FF00.
//   4. Backpressure: hold out_ready=0 for 5 cycles in DONE -> product and out_valid stable, in_ready=0.
//      Then out_ready=1 -> IDLE the next cycle. Back-to-back accepts are spaced K+2 cycles apart.
//   5. clear=1 on the 4th RUN cycle -> next cycle: out_valid=0, in_ready=1, busy=0, product=0.
//      Then signed 7*(-6) -> 0xFFFF_FFD6.
//   6. M=0x0000, Q=0x1234 -> product=0.
//      With BOOTH_ZERO_BYPASS_EN: out_valid 1 cycle after accept. Without it: 8 cycles.
//      Also repeat a random 1000-op signed/unsigned sweep at DATA_WIDTH=8 and 32 against a reference model.

Source files
------------

// File: rtl/booth_pkg.sv
// Shared types and helpers for the radix-4 Booth multiplier: FSM states,
// the recoded digit encoding and iteration/counter sizing functions.
package booth_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // One radix-4 Booth digit: magnitude is 0, 1 or 2, with a separate sign.
    typedef struct packed {
        logic neg;
        logic two;
        logic zero;
    } booth_digit_t;

    // Unsigned operands get one extra digit so the top digit is never negative.
    function automatic int iter_count(input int width, input logic signed_mode);
        return signed_mode ? (width / 2) : (width / 2 + 1);
    endfunction

    function automatic int cnt_width(input int width);
        return $clog2(width / 2 + 2);
    endfunction

endpackage

// File: rtl/booth_r4_recoder.sv
// Combinational radix-4 Booth recoder: maps the window {q1, q0, q[-1]}
// onto a signed digit in {-2, -1, 0, +1, +2}.
module booth_r4_recoder
    import booth_pkg::*;
(
    input  logic [2:0]   window,
    output booth_digit_t digit
);

    always_comb begin
        digit = '{neg: 1'b0, two: 1'b0, zero: 1'b1};
        case (window)
            3'b001, 3'b010: digit = '{neg: 1'b0, two: 1'b0, zero: 1'b0};
            3'b011:         digit = '{neg: 1'b0, two: 1'b1, zero: 1'b0};
            3'b100:         digit = '{neg: 1'b1, two: 1'b1, zero: 1'b0};
            3'b101, 3'b110: digit = '{neg: 1'b1, two: 1'b0, zero: 1'b0};
            default:        digit = '{neg: 1'b0, two: 1'b0, zero: 1'b1};
        endcase
    end

endmodule

// File: rtl/booth_radix4_multiplier.sv
// Sequential radix-4 Booth multiplier, signed or unsigned per operation.
// Optional feature: define BOOTH_ZERO_BYPASS_EN to skip iterations when an operand is zero.
module booth_radix4_multiplier
    import booth_pkg::*;
#(
    parameter int DATA_WIDTH   = 16,
    parameter int OUTPUT_WIDTH = 2 * DATA_WIDTH
) (
    input  logic                    clk,
    input  logic                    clear,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [DATA_WIDTH-1:0]   multiplicand,
    input  logic [DATA_WIDTH-1:0]   multiplier,
    input  logic                    signed_mode,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [OUTPUT_WIDTH-1:0] product,
    output logic                    busy
);

    localparam int AW = DATA_WIDTH + 2;
    localparam int CW = cnt_width(DATA_WIDTH);

    if (OUTPUT_WIDTH != 2 * DATA_WIDTH) begin : g_bad_output_width
        $error("booth_radix4_multiplier: OUTPUT_WIDTH must equal 2*DATA_WIDTH");
    end
    if ((DATA_WIDTH % 2) != 0 || DATA_WIDTH < 4) begin : g_bad_data_width
        $error("booth_radix4_multiplier: DATA_WIDTH must be even and >= 4");
    end

    state_t                  state, state_next;
    logic [AW-1:0]           acc, m_reg, q_reg;
    logic                    q_m1;
    logic                    mode_reg;
    logic [CW-1:0]           cnt;
    logic [OUTPUT_WIDTH-1:0] product_reg;

    logic                    accept;
    logic                    zero_bypass;
    logic                    last_iter;
    booth_digit_t            digit;
    logic [AW-1:0]           pp_mag, pp, acc_sum;
    logic [2*AW:0]           shift_in, shift_out;
    logic [AW-1:0]           acc_next, q_next;
    logic                    q_m1_next;
    logic [2*AW-1:0]         full_next;
    logic [OUTPUT_WIDTH-1:0] product_calc;

    assign accept    = in_valid && (state == IDLE);
    assign last_iter = (cnt == CW'(1));

`ifdef BOOTH_ZERO_BYPASS_EN
    assign zero_bypass = (multiplicand == '0) || (multiplier == '0);
`else
    assign zero_bypass = 1'b0;
`endif

    booth_r4_recoder u_recoder (
        .window ({q_reg[1], q_reg[0], q_m1}),
        .digit  (digit)
    );

    // One iteration: add d*M into the A half, then arithmetic-shift {A,Q,q[-1]} by two.
    always_comb begin
        pp_mag    = digit.zero ? '0 : (digit.two ? {m_reg[AW-2:0], 1'b0} : m_reg);
        pp        = digit.neg ? -pp_mag : pp_mag;
        acc_sum   = acc + pp;
        shift_in  = {acc_sum, q_reg, q_m1};
        shift_out = {{2{acc_sum[AW-1]}}, shift_in[2*AW:2]};
        acc_next  = shift_out[2*AW:AW+1];
        q_next    = shift_out[AW:1];
        q_m1_next = shift_out[0];
        full_next = {acc_next, q_next};
        // Signed runs shift W bits, unsigned runs W+2, so the product sits at a different offset.
        product_calc = OUTPUT_WIDTH'(mode_reg ? (full_next >> 2) : full_next);
    end

    always_ff @(posedge clk) begin
        if (clear) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept) state_next = zero_bypass ? DONE : RUN;
            RUN:     if (last_iter) state_next = DONE;
            DONE:    if (out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state == IDLE);
        out_valid = (state == DONE);
        busy      = (state != IDLE);
        product   = product_reg;
    end

    always_ff @(posedge clk) begin
        if (clear) begin
            acc         <= '0;
            m_reg       <= '0;
            q_reg       <= '0;
            q_m1        <= 1'b0;
            mode_reg    <= 1'b0;
            cnt         <= '0;
            product_reg <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        acc      <= '0;
                        m_reg    <= {{2{multiplicand[DATA_WIDTH-1] & signed_mode}}, multiplicand};
                        q_reg    <= {{2{multiplier[DATA_WIDTH-1] & signed_mode}}, multiplier};
                        q_m1     <= 1'b0;
                        mode_reg <= signed_mode;
                        cnt      <= CW'(iter_count(DATA_WIDTH, signed_mode));
                        if (zero_bypass) product_reg <= '0;
                    end
                end
                RUN: begin
                    acc   <= acc_next;
                    q_reg <= q_next;
                    q_m1  <= q_m1_next;
                    cnt   <= cnt - CW'(1);
                    if (last_iter) product_reg <= product_calc;
                end
                default: ;
            endcase
        end
    end

endmodule
